instr_sequencer: RTL

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer_pkg.sv | 32 +++
 rtl/instr_sequencer_prog_mem.sv | 36 +++
 rtl/instr_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared types for the instruction sequencer: opcodes, instruction word layout
// and sequencer FSM states.
package instr_sequencer_pkg;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        AND = 3'd2,
        OR  = 3'd3,
        XOR = 3'd4,
        MUL = 3'd5,
        DIV = 3'd6,
        CMP = 3'd7
    } opcode_e;

    typedef struct packed {
        opcode_e    opcode;
        logic [7:0] a;
        logic [7:0] b;
    } instr_t;

    localparam int INSTR_W = $bits(instr_t);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/instr_sequencer_prog_mem.sv
// Program store: PROG_DEPTH x 19 array, one synchronous write port and one
// synchronous read port whose output register doubles as the issue register.
module seq_prog_mem
    import instr_sequencer_pkg::*;
#(
    parameter int PROG_DEPTH = 16,
    parameter int AW         = $clog2(PROG_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  instr_t        wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output instr_t        rd_data
);

    instr_t mem [PROG_DEPTH];

    // Array is deliberately left out of reset so a program survives it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches a stored program and issues it to an execute
// unit one instruction at a time. Define SEQ_LOOP_EN to add the loop input.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int PROG_DEPTH = 16,
    parameter int AW         = $clog2(PROG_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
`ifdef SEQ_LOOP_EN
    input  logic          loop,
`endif
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [18:0]   prog_wdata,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          issue_ready,
    input  logic          res_valid,
    input  logic [7:0]    res_data,
    output logic [2:0]    opcode,
    output logic [7:0]    a,
    output logic [7:0]    b,
    output logic          issue_valid,
    output logic [7:0]    last_result,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done
);

    // state   | meaning
    // IDLE    | waiting for start; program writes accepted
    // FETCH   | reading mem[pc] into the issue register
    // ISSUE   | instruction presented until issue_ready
    // WAIT    | waiting for res_valid from the execute unit
    // DONE    | one-cycle done pulse, then back to IDLE

    localparam logic [AW:0] DEPTH_L = (AW+1)'(PROG_DEPTH);

    seq_state_e    state, state_nxt;
    logic [AW-1:0] pc_nxt;
    logic [AW:0]   len_q, len_nxt, len_eff;
    logic [7:0]    last_nxt;
    logic          rd_en;
    logic          is_last;
    instr_t        rd_data;

    assign len_eff = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    assign is_last = ({1'b0, pc} == (len_q - (AW+1)'(1)));

    seq_prog_mem #(
        .PROG_DEPTH (PROG_DEPTH),
        .AW         (AW)
    ) u_prog_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (prog_we && (state == S_IDLE)),
        .wr_addr (prog_addr),
        .wr_data (instr_t'(prog_wdata)),
        .rd_en   (rd_en),
        .rd_addr (pc),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= '0;
            len_q       <= '0;
            last_result <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            len_q       <= len_nxt;
            last_result <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        len_nxt   = len_q;
        last_nxt  = last_result;
        rd_en     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    len_nxt   = len_eff;
                    pc_nxt    = '0;
                    state_nxt = (len_eff == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                rd_en     = 1'b1;
                state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (issue_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (res_valid) begin
                    last_nxt = res_data;
                    if (is_last) begin
`ifdef SEQ_LOOP_EN
                        if (loop) begin
                            pc_nxt    = '0;
                            state_nxt = S_FETCH;
                        end else begin
                            state_nxt = S_DONE;
                        end
`else
                        state_nxt = S_DONE;
`endif
                    end else begin
                        pc_nxt    = pc + AW'(1);
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign opcode      = rd_data.opcode;
    assign a           = rd_data.a;
    assign b           = rd_data.b;
    assign issue_valid = (state == S_ISSUE);
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);

endmodule
